mem_access_arbiter: RTL and testbench
=====================================

# mem_access_arbiter

Sequencer and round-robin arbiter that shares the single memory controller port (16-bit address, 32-bit read data) between two requesters: the processor-side requester 0 and the host/input-side requester 1. It sits in the top-level module between the requesters and the memory controller instance. It grants one read at a time, issues it to the controller, and counts the controller's fixed read latency. It then returns the captured data to the granted requester with a one-cycle valid pulse.

## Interface
Parameters:
- ADDR_W, 16, address width (matches memory controller addr)
- DATA_W, 32, read data width (matches memory controller data)
- RD_LAT, 2, cycles from mem_en to valid mem_data; legal range 1..15

Ports:
- sys_clk  in  1  single clock; all state on rising edge
- sys_reset  in  1  asynchronous, active-low reset (0 = reset)
- req0  in  1  requester 0 read request; held until gnt0
- addr0  in  ADDR_W  requester 0 address; stable while req0=1
- gnt0  out  1  one-cycle grant pulse to requester 0
- rvalid0  out  1  one-cycle read-data-valid pulse to requester 0
- req1, addr1, gnt1, rvalid1: same as above, for requester 1
- rdata  out  DATA_W  shared read data; meaningful only with rvalid0/rvalid1
- mem_en  out  1  one-cycle read strobe to memory controller
- mem_addr  out  ADDR_W  address to memory controller
- mem_data  in  DATA_W  controller read data, valid RD_LAT cycles after mem_en
- busy  out  1  1 whenever state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- Arbitration happens only in IDLE and RESP, using the req values sampled at the clock edge:
  - Only one req high: grant that requester.
  - Both high: grant the requester named by the 1-bit pointer prio.
  - After any grant to requester N, prio becomes the other requester.
- Transitions:
  - IDLE to ISSUE when arbitration grants; otherwise stay in IDLE.
  - ISSUE to WAIT always.
  - WAIT to RESP when lat_cnt reaches 0.
  - RESP to ISSUE when arbitration grants; otherwise RESP to IDLE.
- On a grant: latch the owner id and addrN into mem_addr.
- ISSUE (1 cycle): mem_en=1 and gntN=1 for the owner. Load lat_cnt = RD_LAT-1.
- WAIT (RD_LAT cycles): lat_cnt decrements each cycle. In the cycle where lat_cnt==0, capture mem_data into the rdata register.
- RESP (1 cycle): rvalidN=1 for the owner; rdata holds the captured data.
- rdata and mem_addr hold their values until overwritten. gnt, rvalid and mem_en are single-cycle pulses.
- A requester must deassert req in the cycle after gnt, unless it wants a further read. If req is still high in RESP, it is treated as a new request.
- Dropping req before grant withdraws the request; no side effects.
- addr changing while req=1 before grant is a protocol violation; the value sampled at the arbitration edge is used.
- RD_LAT outside 1..15 is illegal; this is flagged by a simulation-time check at elaboration.
- Only reads are supported. The controller has no write port.

## Timing
- Reset (sys_reset=0, asynchronous): state=IDLE, prio=0, lat_cnt=0. All outputs reset to 0: gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en, mem_addr, busy.
- Reset asserted mid-transaction aborts it immediately: no rvalid is ever issued for it, and the requester must re-request.
- After sys_reset deasserts, the first arbitration occurs at the first rising edge.
- req sampled high at edge E (state IDLE):
  - gnt and mem_en in cycle E+1
  - mem_data sampled in cycle E+1+RD_LAT
  - rvalid in cycle E+2+RD_LAT
- Back-to-back throughput: one read per RD_LAT+2 cycles, because RESP overlaps arbitration.
- Simultaneous req and grant in the same cycle: the grant refers to the request sampled at the previous edge.
- The pointer flips only on an actual grant. An idle cycle does not change prio.

## Test plan
All scenarios use RD_LAT=2.
- Reset: drive sys_reset=0 with random inputs → all outputs 0 and busy=0. Release → no activity until a req is seen.
- Single read: req0=1, addr0=0x0010 sampled at edge E; the memory model returns 0xDEADBEEF two cycles after mem_en → expect:
  - gnt0, mem_en=1, mem_addr=0x0010 at E+1
  - rvalid0=1, rdata=0xDEADBEEF at E+4
  - busy 1 from E+1 through E+4
- Simultaneous requests after reset: req0 and req1 both high at E → expect:
  - gnt0 at E+1 and rvalid0 at E+4
  - gnt1 at E+5 and rvalid1 at E+8
  - rvalid1 never coincides with rvalid0
- Sustained contention: req0 and req1 held high for 8 grants → grant order is 0,1,0,1,...; each grant occurs exactly 4 cycles after the previous one, and there are no idle cycles.
- Mid-operation reset: sys_reset=0 in the second WAIT cycle of a req1 read (addr1=0xFFFF) → rvalid1 never asserts and outputs clear at once. After release, with both reqs high, requester 0 is granted first.
- Lone requester fairness: only req1 active for 3 reads, then req0 and req1 together → the next grant goes to requester 0 (prio=0 after each gnt1).

Source files
------------

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//
// Two-requester round-robin arbiter and read sequencer for a single memory
// controller port. It grants one read at a time and issues it with a
// one-cycle mem_en strobe. It then waits the controller's fixed read latency,
// captures the data, and returns it to the owner with a one-cycle rvalid.
//
// Ports:
//   sys_clk            clock, all state on rising edge
//   sys_reset          asynchronous active-low reset
//   req0/addr0         requester 0 read request and address
//   gnt0/rvalid0       requester 0 grant pulse and read-data-valid pulse
//   req1/addr1         requester 1 read request and address
//   gnt1/rvalid1       requester 1 grant pulse and read-data-valid pulse
//   rdata              shared read data, meaningful with rvalid0/rvalid1
//   mem_en/mem_addr    read strobe and address to the memory controller
//   mem_data           controller read data, valid RD_LAT cycles after mem_en
//   busy               high whenever the sequencer is not idle
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction; arbitrate the sampled requests
// ISSUE | mem_en and gnt for the owner; load the latency counter
// WAIT  | count down the read latency; capture mem_data at terminal count
// RESP  | rvalid for the owner; arbitrate the next request in parallel

module mem_access_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("mem_access_arbiter: RD_LAT=%0d is outside the legal range 1..15", RD_LAT);
    end

    localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;
    logic       prio;
    logic       owner;
    logic [3:0] lat_cnt;

    logic grant_any;
    logic grant_id;

    // With a single request the lone requester wins; on contention the
    // pointer decides.
    always_comb begin
        grant_any = req0 | req1;
        grant_id  = (req0 & req1) ? prio : req1;
    end

    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state    <= IDLE;
            prio     <= 1'b0;
            owner    <= 1'b0;
            lat_cnt  <= 4'd0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata    <= '0;
            mem_en   <= 1'b0;
            mem_addr <= '0;
            busy     <= 1'b0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            mem_en  <= 1'b0;

            case (state)
                // RESP shares the arbitration path with IDLE so a queued
                // request issues without an idle cycle in between.
                IDLE, RESP: begin
                    if (grant_any) begin
                        state    <= ISSUE;
                        owner    <= grant_id;
                        prio     <= ~grant_id;
                        mem_addr <= grant_id ? addr1 : addr0;
                        gnt0     <= ~grant_id;
                        gnt1     <= grant_id;
                        mem_en   <= 1'b1;
                        busy     <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                ISSUE: begin
                    state   <= WAIT;
                    lat_cnt <= LAT_LOAD;
                    busy    <= 1'b1;
                end

                WAIT: begin
                    busy <= 1'b1;
                    if (lat_cnt == 4'd0) begin
                        state   <= RESP;
                        rdata   <= mem_data;
                        rvalid0 <= ~owner;
                        rvalid1 <= owner;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_reset = 1'b0;
    logic        req0 = 1'b0;
    logic [15:0] addr0 = '0;
    logic        gnt0;
    logic        rvalid0;
    logic        req1 = 1'b0;
    logic [15:0] addr1 = '0;
    logic        gnt1;
    logic        rvalid1;
    logic [31:0] rdata;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_data = '0;
    logic        busy;

    logic [31:0] mem_stage = '0;

    int checks = 0;
    int errors = 0;

    mem_access_arbiter #(
        .ADDR_W(16),
        .DATA_W(32),
        .RD_LAT(2)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_reset(sys_reset),
        .req0     (req0),
        .addr0    (addr0),
        .gnt0     (gnt0),
        .rvalid0  (rvalid0),
        .req1     (req1),
        .addr1    (addr1),
        .gnt1     (gnt1),
        .rvalid1  (rvalid1),
        .rdata    (rdata),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] mem_fn(input logic [15:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        return {a, ~a};
    endfunction

    // Memory controller model: data is present only in the one cycle that
    // lies exactly two cycles after the mem_en cycle.
    always @(posedge sys_clk) begin
        mem_stage <= mem_en ? mem_fn(mem_addr) : 32'h0;
        mem_data  <= mem_stage;
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt0"},     64'(gnt0),     64'd0);
        chk({tag, "_gnt1"},     64'(gnt1),     64'd0);
        chk({tag, "_rvalid0"},  64'(rvalid0),  64'd0);
        chk({tag, "_rvalid1"},  64'(rvalid1),  64'd0);
        chk({tag, "_rdata"},    64'(rdata),    64'd0);
        chk({tag, "_mem_en"},   64'(mem_en),   64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_busy"},     64'(busy),     64'd0);
    endtask

    initial begin
        int ng;
        int last;
        logic seen_rv1;

        // ---------------- reset with random inputs ----------------
        sys_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req0  = 1'($urandom);
            req1  = 1'($urandom);
            addr0 = 16'($urandom);
            addr1 = 16'($urandom);
            tick();
        end
        chk_all_zero("rst");
        req0 = 1'b0;
        req1 = 1'b0;
        sys_reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("post_rst_busy",   64'(busy),   64'd0);
        chk("post_rst_mem_en", 64'(mem_en), 64'd0);
        chk("post_rst_gnt",    64'({gnt0, gnt1}), 64'd0);

        // ---------------- single read ----------------
        req0  = 1'b1;
        addr0 = 16'h0010;
        tick();                                    // E+1
        chk("single_gnt0",     64'(gnt0),     64'd1);
        chk("single_gnt1",     64'(gnt1),     64'd0);
        chk("single_mem_en",   64'(mem_en),   64'd1);
        chk("single_mem_addr", 64'(mem_addr), 64'h0010);
        chk("single_busy1",    64'(busy),     64'd1);
        req0 = 1'b0;
        tick();                                    // E+2
        chk("single_gnt_pulse",   64'(gnt0),   64'd0);
        chk("single_mem_en_pulse", 64'(mem_en), 64'd0);
        chk("single_busy2",       64'(busy),   64'd1);
        tick();                                    // E+3
        chk("single_early_rv",    64'(rvalid0), 64'd0);
        chk("single_busy3",       64'(busy),    64'd1);
        tick();                                    // E+4
        chk("single_rvalid0",  64'(rvalid0), 64'd1);
        chk("single_rvalid1",  64'(rvalid1), 64'd0);
        chk("single_rdata",    64'(rdata),   64'hDEADBEEF);
        chk("single_busy4",    64'(busy),    64'd1);
        tick();                                    // E+5
        chk("single_rv_pulse", 64'(rvalid0), 64'd0);
        chk("single_idle",     64'(busy),    64'd0);
        chk("single_rdata_hold", 64'(rdata), 64'hDEADBEEF);
        chk("single_addr_hold",  64'(mem_addr), 64'h0010);

        // ---------------- simultaneous requests after reset ----------------
        sys_reset = 1'b0;
        tick();
        sys_reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 16'h0100;
        addr1 = 16'h0200;
        tick();                                    // E+1
        chk("sim_gnt0",     64'(gnt0),     64'd1);
        chk("sim_gnt1_a",   64'(gnt1),     64'd0);
        chk("sim_addr0",    64'(mem_addr), 64'h0100);
        req0 = 1'b0;
        tick();
        tick();
        tick();                                    // E+4
        chk("sim_rvalid0",  64'(rvalid0), 64'd1);
        chk("sim_rv1_excl", 64'(rvalid1), 64'd0);
        chk("sim_rdata0",   64'(rdata),   64'h0100FEFF);
        tick();                                    // E+5
        chk("sim_gnt1",     64'(gnt1),     64'd1);
        chk("sim_gnt0_b",   64'(gnt0),     64'd0);
        chk("sim_addr1",    64'(mem_addr), 64'h0200);
        chk("sim_mem_en",   64'(mem_en),   64'd1);
        req1 = 1'b0;
        tick();
        tick();
        tick();                                    // E+8
        chk("sim_rvalid1",  64'(rvalid1), 64'd1);
        chk("sim_rv0_excl", 64'(rvalid0), 64'd0);
        chk("sim_rdata1",   64'(rdata),   64'h0200FDFF);
        tick();
        chk("sim_idle",     64'(busy),    64'd0);

        // ---------------- sustained contention ----------------
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 16'h0300;
        addr1 = 16'h0400;
        ng   = 0;
        last = 0;
        for (int c = 0; c < 40 && ng < 8; c++) begin
            tick();
            if (ng > 0) chk("sus_busy", 64'(busy), 64'd1);
            if (gnt0 | gnt1) begin
                chk("sus_order", 64'({gnt1, gnt0}), (ng % 2 == 0) ? 64'd1 : 64'd2);
                chk("sus_addr",  64'(mem_addr), (ng % 2 == 0) ? 64'h0300 : 64'h0400);
                if (ng > 0) chk("sus_gap", 64'(c - last), 64'd4);
                last = c;
                ng++;
            end
        end
        chk("sus_count", 64'(ng), 64'd8);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int c = 0; c < 10 && busy; c++) tick();
        chk("sus_drain", 64'(busy), 64'd0);

        // ---------------- mid-operation reset ----------------
        req1  = 1'b1;
        addr1 = 16'hFFFF;
        tick();                                    // ISSUE
        chk("mid_gnt1",  64'(gnt1),     64'd1);
        chk("mid_addr",  64'(mem_addr), 64'hFFFF);
        req1 = 1'b0;
        tick();                                    // first WAIT
        tick();                                    // second WAIT
        chk("mid_busy_pre", 64'(busy), 64'd1);
        sys_reset = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        seen_rv1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen_rv1 = seen_rv1 | rvalid1;
        end
        chk("mid_no_rvalid1", 64'(seen_rv1), 64'd0);
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 16'h0500;
        addr1 = 16'h0600;
        sys_reset = 1'b1;
        tick();
        chk("mid_after_gnt", 64'({gnt1, gnt0}), 64'd1);
        chk("mid_after_addr", 64'(mem_addr), 64'h0500);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_after_rv", 64'({rvalid1, rvalid0}), 64'd1);
        chk("mid_after_rdata", 64'(rdata), 64'h0500FAFF);
        tick();
        chk("mid_after_idle", 64'(busy), 64'd0);

        // ---------------- lone requester fairness ----------------
        for (int r = 0; r < 3; r++) begin
            req1  = 1'b1;
            addr1 = 16'h0700 + 16'(r);
            tick();
            chk("lone_gnt1", 64'({gnt1, gnt0}), 64'd2);
            req1 = 1'b0;
            tick();
            tick();
            tick();
            chk("lone_rv1",   64'({rvalid1, rvalid0}), 64'd2);
            chk("lone_rdata", 64'(rdata), 64'(mem_fn(16'h0700 + 16'(r))));
        end
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 16'h0800;
        addr1 = 16'h0900;
        tick();
        chk("fair_gnt0", 64'({gnt1, gnt0}), 64'd1);
        chk("fair_addr", 64'(mem_addr), 64'h0800);
        req0 = 1'b0;
        req1 = 1'b0;
        for (int c = 0; c < 10 && busy; c++) tick();
        chk("final_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
